// File: rtl/axi4_m_to_read_fifos_credit.sv
// AXI4 read bridge: user AR FIFO in, R FIFO out, with R-space credit so the
// slave is never throttled, plus an outstanding-burst limit and fill flags.
module axi4_m_to_read_fifos_credit #(
    parameter int A                     = 32,
    parameter int N                     = 4,
    parameter int I                     = 1,
    parameter int AR_D                  = 4,
    parameter int R_D                   = 64,
    parameter int MAX_OUTSTANDING       = 4,
    parameter int WATERMARK             = 0,
    parameter int USE_ADVANCED_PROTOCOL = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    output logic [A-1:0]            m_araddr,
    output logic [1:0]              m_arburst,
    output logic [I-1:0]            m_arid,
    output logic [7:0]              m_arlen,
    output logic [2:0]              m_arsize,
    output logic [3:0]              m_arcache,
    output logic                    m_arlock,
    output logic [2:0]              m_arprot,
    output logic [3:0]              m_arqos,
    output logic [3:0]              m_arregion,
    output logic                    m_arvalid,
    input  logic                    m_arready,
    input  logic [I-1:0]            m_rid,
    input  logic [8*N-1:0]          m_rdata,
    input  logic [1:0]              m_rresp,
    input  logic                    m_rlast,
    input  logic                    m_rvalid,
    output logic                    m_rready,
    input  logic [A-1:0]            u_araddr,
    input  logic [1:0]              u_arburst,
    input  logic [I-1:0]            u_arid,
    input  logic [7:0]              u_arlen,
    input  logic [2:0]              u_arsize,
    input  logic [3:0]              u_arcache,
    input  logic                    u_arlock,
    input  logic [2:0]              u_arprot,
    input  logic [3:0]              u_arqos,
    input  logic [3:0]              u_arregion,
    output logic [I-1:0]            u_rid,
    output logic [8*N-1:0]          u_rdata,
    output logic [1:0]              u_rresp,
    output logic                    u_rlast,
    input  logic                    ar_wr_en,
    output logic                    ar_wr_full,
    input  logic                    r_rd_en,
    output logic                    r_rd_empty,
    output logic [$clog2(R_D):0]    r_count,
    output logic                    r_watermark,
    output logic                    r_topped_off,
    output logic                    ar_len_err
);
    localparam int AAW = $clog2(AR_D);
    localparam int RAW = $clog2(R_D);
    localparam int CW  = RAW + 1;
    localparam int OW  = $clog2(MAX_OUTSTANDING + 1);

    typedef struct packed {
        logic [A-1:0] addr;
        logic [1:0]   burst;
        logic [I-1:0] id;
        logic [7:0]   len;
        logic [2:0]   size;
        logic [3:0]   cache;
        logic         lock;
        logic [2:0]   prot;
        logic [3:0]   qos;
        logic [3:0]   region;
    } ar_t;

    typedef struct packed {
        logic [I-1:0]   id;
        logic [1:0]     resp;
        logic           last;
        logic [8*N-1:0] data;
    } r_t;

    ar_t             ar_mem [AR_D];
    r_t              r_mem [R_D];
    ar_t             ar_in, head;
    r_t              r_in, r_head;
    logic [AAW:0]    ar_wp, ar_rp;
    logic [RAW:0]    r_wp, r_rp;
    logic [CW-1:0]   reserved;
    logic [OW-1:0]   outstanding;
    logic [8:0]      beats;
    logic [31:0]     free;
    logic            ar_empty, ar_full, r_full, len_bad;
    logic            ar_push, ar_pop, ar_hs, r_push, r_pop;

    always_comb begin
        ar_in        = '0;
        ar_in.addr   = u_araddr;
        ar_in.burst  = u_arburst;
        ar_in.id     = u_arid;
        ar_in.len    = u_arlen;
        ar_in.size   = u_arsize;
        if (USE_ADVANCED_PROTOCOL != 0) begin
            ar_in.cache  = u_arcache;
            ar_in.lock   = u_arlock;
            ar_in.prot   = u_arprot;
            ar_in.qos    = u_arqos;
            ar_in.region = u_arregion;
        end
    end

    assign r_in = '{id: m_rid, resp: m_rresp, last: m_rlast, data: m_rdata};

    assign ar_empty   = (ar_wp == ar_rp);
    assign ar_full    = (ar_wp[AAW] != ar_rp[AAW]) && (ar_wp[AAW-1:0] == ar_rp[AAW-1:0]);
    assign head       = ar_mem[ar_rp[AAW-1:0]];
    assign r_head     = r_mem[r_rp[RAW-1:0]];
    assign r_count    = r_wp - r_rp;
    assign r_full     = (r_count == CW'(R_D));
    assign r_rd_empty = (r_count == '0);
    assign ar_wr_full = ar_full;

    // Credit: a burst goes out only when every beat already has a slot reserved.
    assign beats     = {1'b0, head.len} + 9'd1;
    assign free      = 32'(R_D) - 32'(r_count) - 32'(reserved);
    assign len_bad   = ~ar_empty & (32'(beats) > 32'(R_D));
    assign m_arvalid = ~ar_empty & (outstanding < OW'(MAX_OUTSTANDING))
                       & (32'(beats) <= free) & ~len_bad;
    assign m_rready  = ~r_full;

    assign ar_push = ar_wr_en & ~ar_full;
    assign ar_hs   = m_arvalid & m_arready;
    assign ar_pop  = ar_hs | len_bad;
    assign r_push  = m_rvalid & m_rready;
    assign r_pop   = r_rd_en & ~r_rd_empty;

    assign m_araddr   = head.addr;
    assign m_arburst  = head.burst;
    assign m_arid     = head.id;
    assign m_arlen    = head.len;
    assign m_arsize   = head.size;
    assign m_arcache  = head.cache;
    assign m_arlock   = head.lock;
    assign m_arprot   = head.prot;
    assign m_arqos    = head.qos;
    assign m_arregion = head.region;

    assign u_rid   = r_head.id;
    assign u_rresp = r_head.resp;
    assign u_rlast = r_head.last;
    assign u_rdata = r_head.data;

    assign r_watermark = (WATERMARK != 0) && (32'(r_count) >= 32'(WATERMARK));

    always_ff @(posedge clk) begin
        if (ar_push) ar_mem[ar_wp[AAW-1:0]] <= ar_in;
        if (r_push)  r_mem[r_wp[RAW-1:0]]   <= r_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ar_wp        <= '0;
            ar_rp        <= '0;
            r_wp         <= '0;
            r_rp         <= '0;
            reserved     <= '0;
            outstanding  <= '0;
            ar_len_err   <= 1'b0;
            r_topped_off <= (WATERMARK == 0);
        end else begin
            if (ar_push) ar_wp <= ar_wp + 1'b1;
            if (ar_pop)  ar_rp <= ar_rp + 1'b1;
            if (r_push)  r_wp  <= r_wp + 1'b1;
            if (r_pop)   r_rp  <= r_rp + 1'b1;
            reserved <= CW'(32'(reserved) + (ar_hs ? 32'(beats) : 32'd0)
                            - (r_push ? 32'd1 : 32'd0));
            outstanding <= outstanding + OW'(ar_hs) - OW'(r_push & m_rlast);
            if (len_bad) ar_len_err <= 1'b1;
            // With the watermark disabled the FIFO counts as permanently topped off.
            if (WATERMARK == 0)   r_topped_off <= 1'b1;
            else if (r_rd_empty)  r_topped_off <= 1'b0;
            else if (r_watermark) r_topped_off <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) assert (32'(r_count) + 32'(reserved) <= 32'(R_D));
    end
endmodule

// File: tb/tb_axi4_m_to_read_fifos_credit.sv
// Bench for the credit-based AXI read bridge: in-order slave model plus
// scoreboards for AR fields and R beats, and per-cycle credit counters.
module tb_axi4_m_to_read_fifos_credit;
    localparam int A  = 32;
    localparam int N  = 4;
    localparam int I  = 2;
    localparam int RD = 16;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [1:0]  id;
    } bst_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [A-1:0]   m_araddr;
    logic [1:0]     m_arburst;
    logic [I-1:0]   m_arid;
    logic [7:0]     m_arlen;
    logic [2:0]     m_arsize;
    logic [3:0]     m_arcache;
    logic           m_arlock;
    logic [2:0]     m_arprot;
    logic [3:0]     m_arqos;
    logic [3:0]     m_arregion;
    logic           m_arvalid, m_arready;
    logic [I-1:0]   m_rid = '0;
    logic [8*N-1:0] m_rdata = '0;
    logic [1:0]     m_rresp = '0;
    logic           m_rlast = 1'b0;
    logic           m_rvalid = 1'b0;
    logic           m_rready;
    logic [A-1:0]   u_araddr;
    logic [1:0]     u_arburst;
    logic [I-1:0]   u_arid;
    logic [7:0]     u_arlen;
    logic [2:0]     u_arsize;
    logic [3:0]     u_arcache;
    logic           u_arlock;
    logic [2:0]     u_arprot;
    logic [3:0]     u_arqos;
    logic [3:0]     u_arregion;
    logic [I-1:0]   u_rid;
    logic [8*N-1:0] u_rdata;
    logic [1:0]     u_rresp;
    logic           u_rlast;
    logic           ar_wr_en, ar_wr_full, r_rd_en, r_rd_empty;
    logic [4:0]     r_count;
    logic           r_watermark, r_topped_off, ar_len_err;

    logic slave_r_en, slave_ar_rdy;
    assign m_arready = slave_ar_rdy;

    axi4_m_to_read_fifos_credit #(
        .A(A), .N(N), .I(I), .AR_D(4), .R_D(RD), .MAX_OUTSTANDING(2),
        .WATERMARK(8), .USE_ADVANCED_PROTOCOL(0)
    ) dut (
        .clk(clk), .reset(reset),
        .m_araddr(m_araddr), .m_arburst(m_arburst), .m_arid(m_arid), .m_arlen(m_arlen),
        .m_arsize(m_arsize), .m_arcache(m_arcache), .m_arlock(m_arlock), .m_arprot(m_arprot),
        .m_arqos(m_arqos), .m_arregion(m_arregion), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
        .m_rvalid(m_rvalid), .m_rready(m_rready),
        .u_araddr(u_araddr), .u_arburst(u_arburst), .u_arid(u_arid), .u_arlen(u_arlen),
        .u_arsize(u_arsize), .u_arcache(u_arcache), .u_arlock(u_arlock), .u_arprot(u_arprot),
        .u_arqos(u_arqos), .u_arregion(u_arregion),
        .u_rid(u_rid), .u_rdata(u_rdata), .u_rresp(u_rresp), .u_rlast(u_rlast),
        .ar_wr_en(ar_wr_en), .ar_wr_full(ar_wr_full), .r_rd_en(r_rd_en), .r_rd_empty(r_rd_empty),
        .r_count(r_count), .r_watermark(r_watermark), .r_topped_off(r_topped_off),
        .ar_len_err(ar_len_err)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] beat_word(input logic [1:0] id, input logic [31:0] addr,
                                              input int b, input logic last);
        return {27'b0, id, addr[13:12], last, addr[15:0], 16'(b)};
    endfunction

    logic [63:0] exp_ar[$];
    logic [63:0] exp_r[$];
    bst_t        bq[$];
    bst_t        cap;
    logic        ar_hs_f = 1'b0, r_hs_f = 1'b0;
    int          m_cnt = 0, m_res = 0, m_out = 0;
    int          ar_hs_cnt = 0, r_hs_cnt = 0, pop_cnt = 0, sbeat = 0;

    // Monitor: settled values between edges; models describe state after the last edge.
    always @(negedge clk) begin
        ar_hs_f = 1'b0;
        r_hs_f  = 1'b0;
        if (reset) begin
            exp_ar.delete();
            exp_r.delete();
            m_cnt = 0;
            m_res = 0;
            m_out = 0;
        end else begin
            chk("r_count", 64'(r_count), 64'(m_cnt));
            chk("reserved", 64'(dut.reserved), 64'(m_res));
            chk("outstanding", 64'(dut.outstanding), 64'(m_out));
            if (m_rvalid) chk("rready", 64'(m_rready), 64'd1);
            if (m_arvalid && m_arready) begin
                ar_hs_f = 1'b1;
                ar_hs_cnt++;
                cap = '{addr: m_araddr, len: m_arlen, id: m_arid};
                chk("ar_adv_zero", 64'({m_arcache, m_arlock, m_arprot, m_arqos, m_arregion}), 64'd0);
                if (exp_ar.size() == 0) chk("ar_unexpected", 64'd1, 64'd0);
                else chk("ar_fields", {17'b0, m_araddr, m_arlen, m_arid, m_arburst, m_arsize},
                         exp_ar.pop_front());
                for (int b = 0; b <= int'(m_arlen); b++)
                    exp_r.push_back(beat_word(m_arid, m_araddr, b, b == int'(m_arlen)));
                m_res += int'(m_arlen) + 1;
                m_out++;
            end
            if (m_rvalid && m_rready) begin
                r_hs_f = 1'b1;
                r_hs_cnt++;
                m_res--;
                m_cnt++;
                if (m_rlast) m_out--;
            end
            if (ar_wr_en && !ar_wr_full && int'(u_arlen) + 1 <= RD)
                exp_ar.push_back({17'b0, u_araddr, u_arlen, u_arid, u_arburst, u_arsize});
            if (r_rd_en && !r_rd_empty) begin
                pop_cnt++;
                m_cnt--;
                if (exp_r.size() == 0) chk("r_unexpected", 64'd1, 64'd0);
                else chk("r_beat", {27'b0, u_rid, u_rresp, u_rlast, u_rdata}, exp_r.pop_front());
            end
        end
    end

    // In-order slave; presents beats 2 time units after each edge.
    always begin
        @(posedge clk);
        #2;
        if (reset) begin
            bq.delete();
            sbeat    = 0;
            m_rvalid = 1'b0;
        end else begin
            if (r_hs_f && bq.size() > 0) begin
                if (sbeat == int'(bq[0].len)) begin
                    void'(bq.pop_front());
                    sbeat = 0;
                end else sbeat++;
            end
            if (ar_hs_f) bq.push_back(cap);
            if (slave_r_en && bq.size() > 0) begin
                m_rvalid = 1'b1;
                m_rid    = bq[0].id;
                m_rresp  = bq[0].addr[13:12];
                m_rlast  = (sbeat == int'(bq[0].len));
                m_rdata  = {bq[0].addr[15:0], 16'(sbeat)};
            end else m_rvalid = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_ar(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] id);
        int k = 0;
        while (ar_wr_full && k < 50) begin tick(); k++; end
        if (k >= 50) chk("push_timeout", 64'd1, 64'd0);
        u_araddr = addr; u_arlen = len; u_arid = id;
        ar_wr_en = 1'b1;
        tick();
        ar_wr_en = 1'b0;
    endtask

    task automatic pop_n(input int n);
        for (int i = 0; i < n; i++) begin
            int k = 0;
            while (r_rd_empty && k < 50) begin tick(); k++; end
            if (k >= 50) chk("pop_timeout", 64'd1, 64'd0);
            r_rd_en = 1'b1;
            tick();
            r_rd_en = 1'b0;
        end
    endtask

    task automatic drain();
        int k = 0;
        while (k < 400 && !(exp_r.size() == 0 && exp_ar.size() == 0 && r_rd_empty && !m_rvalid)) begin
            r_rd_en = !r_rd_empty;
            tick();
            r_rd_en = 1'b0;
            k++;
        end
        if (k >= 400) chk("drain_timeout", 64'd1, 64'd0);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_arvalid"}, 64'(m_arvalid), 64'd0);
        chk({tag, "_empty"}, 64'(r_rd_empty), 64'd1);
        chk({tag, "_full"}, 64'(ar_wr_full), 64'd0);
        chk({tag, "_count"}, 64'(r_count), 64'd0);
        chk({tag, "_wm"}, 64'(r_watermark), 64'd0);
        chk({tag, "_top"}, 64'(r_topped_off), 64'd0);
        chk({tag, "_lenerr"}, 64'(ar_len_err), 64'd0);
        chk({tag, "_reserved"}, 64'(dut.reserved), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, base_r, k;
        reset = 1'b1; ar_wr_en = 1'b0; r_rd_en = 1'b0;
        slave_r_en = 1'b0; slave_ar_rdy = 1'b0;
        u_araddr = '0; u_arlen = '0; u_arid = '0; u_arburst = 2'b01; u_arsize = 3'd2;
        u_arcache = 4'hf; u_arlock = 1'b1; u_arprot = 3'd5; u_arqos = 4'ha; u_arregion = 4'h3;
        repeat (3) tick();
        check_reset_values("rst_held");
        reset = 1'b0;
        tick();
        check_reset_values("rst_after");

        // Credit: two 8-beat bursts fill R; the third waits for 8 pops.
        slave_r_en = 1'b1; slave_ar_rdy = 1'b1;
        base = ar_hs_cnt;
        push_ar(32'h1000, 8'd7, 2'd1);
        push_ar(32'h2000, 8'd7, 2'd2);
        push_ar(32'h3000, 8'd7, 2'd3);
        repeat (40) tick();
        chk("t1_count", 64'(r_count), 64'd16);
        chk("t1_arvalid_full", 64'(m_arvalid), 64'd0);
        chk("t1_issued", 64'(ar_hs_cnt - base), 64'd2);
        slave_ar_rdy = 1'b0;
        pop_n(7);
        chk("t1_arvalid_7", 64'(m_arvalid), 64'd0);
        pop_n(1);
        chk("t1_arvalid_8", 64'(m_arvalid), 64'd1);
        slave_ar_rdy = 1'b1;
        drain();

        // Outstanding limit of two with a stalled slave.
        slave_r_en = 1'b0;
        base = ar_hs_cnt;
        base_r = r_hs_cnt;
        for (int i = 0; i < 4; i++) push_ar(32'h0100 * (i + 1), 8'd0, 2'(i));
        repeat (10) tick();
        chk("t2_issued", 64'(ar_hs_cnt - base), 64'd2);
        chk("t2_arvalid", 64'(m_arvalid), 64'd0);
        slave_r_en = 1'b1;
        k = 0;
        while (r_hs_cnt == base_r && k < 20) begin tick(); k++; end
        chk("t2_rlast_seen", 64'(r_hs_cnt - base_r), 64'd1);
        chk("t2_issued_at_rlast", 64'(ar_hs_cnt - base), 64'd2);
        chk("t2_arvalid_after", 64'(m_arvalid), 64'd1);
        drain();
        chk("t2_total", 64'(ar_hs_cnt - base), 64'd4);

        // Over-length burst is dropped and flagged; the next one proceeds.
        base = ar_hs_cnt;
        chk("t3_err_before", 64'(ar_len_err), 64'd0);
        push_ar(32'h4000, 8'd31, 2'd1);
        push_ar(32'h5000, 8'd0, 2'd2);
        repeat (8) tick();
        chk("t3_err", 64'(ar_len_err), 64'd1);
        chk("t3_issued", 64'(ar_hs_cnt - base), 64'd1);
        drain();
        repeat (3) tick();
        chk("t3_sticky", 64'(ar_len_err), 64'd1);

        // Watermark at 8 beats and topped-off set/clear timing.
        push_ar(32'h6000, 8'd7, 2'd0);
        k = 0;
        while (r_count != 5'd8 && k < 40) begin tick(); k++; end
        chk("t4_count", 64'(r_count), 64'd8);
        chk("t4_wm", 64'(r_watermark), 64'd1);
        chk("t4_top_pre", 64'(r_topped_off), 64'd0);
        tick();
        chk("t4_top", 64'(r_topped_off), 64'd1);
        pop_n(1);
        chk("t4_wm_below", 64'(r_watermark), 64'd0);
        chk("t4_top_hold", 64'(r_topped_off), 64'd1);
        pop_n(7);
        chk("t4_empty", 64'(r_rd_empty), 64'd1);
        chk("t4_top_empty", 64'(r_topped_off), 64'd1);
        tick();
        chk("t4_top_clear", 64'(r_topped_off), 64'd0);

        // Simultaneous AR and R handshakes: net reservation +3.
        slave_r_en = 1'b0; slave_ar_rdy = 1'b1;
        push_ar(32'h7000, 8'd3, 2'd1);
        repeat (3) tick();
        slave_ar_rdy = 1'b0;
        push_ar(32'h8000, 8'd3, 2'd2);
        repeat (2) tick();
        chk("t5_res_pre", 64'(dut.reserved), 64'd4);
        chk("t5_arvalid_pre", 64'(m_arvalid), 64'd1);
        slave_r_en = 1'b1; slave_ar_rdy = 1'b1;
        tick();
        chk("t5_res", 64'(dut.reserved), 64'd7);
        chk("t5_count", 64'(r_count), 64'd1);
        chk("t5_invariant", 64'(32'(r_count) + 32'(dut.reserved) <= RD), 64'd1);
        drain();

        // Reset in the middle of a burst, then a fresh single beat.
        push_ar(32'h9000, 8'd7, 2'd3);
        repeat (4) tick();
        chk("t6_midburst", 64'(r_rd_empty), 64'd0);
        reset = 1'b1;
        tick();
        check_reset_values("t6_rst");
        reset = 1'b0;
        tick();
        check_reset_values("t6_after");
        base = pop_cnt;
        push_ar(32'ha000, 8'd0, 2'd1);
        drain();
        chk("t6_pops", 64'(pop_cnt - base), 64'd1);
        chk("end_exp_r", 64'(exp_r.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
